// File: rtl/ahb_arbiter_param_if.sv
// rtl/ahb_arbiter_param_if.sv - AHB arbitration bus bundle between masters and the arbiter
interface ahb_arbiter_param_if #(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = $clog2(NUM_MASTERS)
);
  logic [NUM_MASTERS-1:0] m_busreq;
  logic [NUM_MASTERS-1:0] m_hlock;
  logic                   hready;
  logic [1:0]             htrans;
  logic [2:0]             hburst;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [MW-1:0]          hmaster;
  logic [MW-1:0]          hmaster_data;
  logic                   hmastlock;

  modport master (
    output m_busreq, m_hlock, hready, htrans, hburst,
    input  hgrant, hmaster, hmaster_data, hmastlock
  );

  modport slave (
    input  m_busreq, m_hlock, hready, htrans, hburst,
    output hgrant, hmaster, hmaster_data, hmastlock
  );
endinterface

// File: rtl/ahb_arbiter_param.sv
// rtl/ahb_arbiter_param.sv - N-master AHB arbiter with priority/round-robin, burst-aware handover and lock hold
module ahb_arbiter_param #(
  parameter int NUM_MASTERS    = 4,
  parameter int MW             = $clog2(NUM_MASTERS),
  parameter int ARB_MODE       = 0,
  parameter int DEFAULT_MASTER = 0
) (
  input logic            hclk,
  input logic            hreset,
  ahb_arbiter_param_if.slave bus
);
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  logic [NUM_MASTERS-1:0] hgrant_q;
  logic [MW-1:0]          hmaster_q;
  logic [MW-1:0]          hmaster_data_q;
  logic                   hmastlock_q;
  logic [MW-1:0]          rr_ptr;
  logic [3:0]             beat_cnt;

  logic [MW-1:0]          holder;
  logic [MW-1:0]          winner;
  logic [3:0]             beat_last;
  logic                   fixed_burst;
  logic                   burst_last;
  logic                   lock_hold;
  logic                   rearb;
  logic                   found;
  int                     idx;

  always_comb begin
    holder = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hgrant_q[i]) holder = MW'(i);
    end
  end

  always_comb begin
    case (bus.hburst[2:1])
      2'b01:   beat_last = 4'd3;
      2'b10:   beat_last = 4'd7;
      2'b11:   beat_last = 4'd15;
      default: beat_last = 4'd0;
    endcase
  end

  assign fixed_burst = (bus.hburst[2:1] != 2'b00);
  assign burst_last  = fixed_burst && (bus.htrans == HT_SEQ) && (beat_cnt == beat_last);
  assign lock_hold   = bus.m_hlock[holder] & bus.m_busreq[holder];
  // BUSY never hands over; SINGLE/INCR may be broken on any non-BUSY beat
  assign rearb = !lock_hold && bus.hready &&
                 ((bus.htrans == HT_IDLE) ||
                  ((bus.htrans != HT_BUSY) && (!fixed_burst || burst_last)));

  always_comb begin
    winner = MW'(DEFAULT_MASTER);
    found  = 1'b0;
    idx    = 0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (bus.m_busreq[i]) winner = MW'(i);
      end
    end else begin
      for (int k = 1; k <= NUM_MASTERS; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_MASTERS;
        if (!found && bus.m_busreq[idx]) begin
          winner = MW'(idx);
          found  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      hgrant_q       <= NUM_MASTERS'(1) << DEFAULT_MASTER;
      hmaster_q      <= MW'(DEFAULT_MASTER);
      hmaster_data_q <= MW'(DEFAULT_MASTER);
      hmastlock_q    <= 1'b0;
      rr_ptr         <= MW'(DEFAULT_MASTER);
      beat_cnt       <= 4'd0;
    end else begin
      if (rearb) begin
        hgrant_q <= NUM_MASTERS'(1) << winner;
        if ((winner != holder) && bus.m_busreq[winner]) rr_ptr <= winner;
      end
      if (bus.hready) begin
        hmaster_q      <= holder;
        hmaster_data_q <= hmaster_q;
        hmastlock_q    <= lock_hold;
        if (bus.htrans == HT_NONSEQ) beat_cnt <= 4'd1;
        else if ((bus.htrans == HT_SEQ) && (beat_cnt != 4'd15)) beat_cnt <= beat_cnt + 4'd1;
      end
    end
  end

  assign bus.hgrant       = hgrant_q;
  assign bus.hmaster      = hmaster_q;
  assign bus.hmaster_data = hmaster_data_q;
  assign bus.hmastlock    = hmastlock_q;
endmodule

// File: tb/tb_ahb_arbiter_param.sv
// tb/tb_ahb_arbiter_param.sv - randomized and directed checks of both arbitration modes against a reference model
module tb_ahb_arbiter_param;
  logic       hclk = 1'b0;
  logic       hreset = 1'b1;
  logic [3:0] busreq = 4'd0;
  logic [3:0] hlock = 4'd0;
  logic       hready = 1'b1;
  logic [1:0] htrans = 2'd0;
  logic [2:0] hburst = 3'd0;

  int tests = 0;
  int fails = 0;
  bit model_valid = 1'b0;

  always #5 hclk = ~hclk;

  ahb_arbiter_param_if #(.NUM_MASTERS(4)) bus0 ();
  ahb_arbiter_param_if #(.NUM_MASTERS(4)) bus1 ();

  assign bus0.m_busreq = busreq;
  assign bus0.m_hlock  = hlock;
  assign bus0.hready   = hready;
  assign bus0.htrans   = htrans;
  assign bus0.hburst   = hburst;
  assign bus1.m_busreq = busreq;
  assign bus1.m_hlock  = hlock;
  assign bus1.hready   = hready;
  assign bus1.htrans   = htrans;
  assign bus1.hburst   = hburst;

  ahb_arbiter_param #(.NUM_MASTERS(4), .ARB_MODE(0), .DEFAULT_MASTER(0)) dut0 (
    .hclk(hclk), .hreset(hreset), .bus(bus0.slave));
  ahb_arbiter_param #(.NUM_MASTERS(4), .ARB_MODE(1), .DEFAULT_MASTER(0)) dut1 (
    .hclk(hclk), .hreset(hreset), .bus(bus1.slave));

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference: grant owner index, pipeline owners, lock flag, beat count and RR pointer per mode
  int  mg[2], mhm[2], mhmd[2], mrr[2], mcnt[2];
  bit  mlk[2];
  int  g, w, blen;
  bit  hold, last, allow;

  function automatic int pick(input int mode, input logic [3:0] req, input int rr);
    int i;
    if (req == 4'd0) return 0;
    for (int k = 1; k <= 4; k++) begin
      i = (mode == 0) ? k - 1 : (rr + k) % 4;
      if (req[i]) return i;
    end
    return 0;
  endfunction

  function automatic int burst_len(input logic [2:0] hb);
    if (hb >= 3'd6) return 16;
    if (hb >= 3'd4) return 8;
    if (hb >= 3'd2) return 4;
    return 0;
  endfunction

  always @(posedge hclk) begin
    for (int m = 0; m < 2; m++) begin
      if (hreset) begin
        mg[m] = 0; mhm[m] = 0; mhmd[m] = 0; mlk[m] = 1'b0; mcnt[m] = 0; mrr[m] = 0;
      end else begin
        g     = mg[m];
        hold  = hlock[g] && busreq[g];
        blen  = burst_len(hburst);
        last  = (blen != 0) && (htrans == 2'd3) && (mcnt[m] == blen - 1);
        allow = !hold && hready && (htrans == 2'd0 || (htrans != 2'd1 && (blen == 0 || last)));
        if (allow) begin
          w = pick(m, busreq, mrr[m]);
          if (w != g && busreq[w]) mrr[m] = w;
          mg[m] = w;
        end
        if (hready) begin
          mhmd[m] = mhm[m];
          mhm[m]  = g;
          mlk[m]  = hold;
          if (htrans == 2'd2) mcnt[m] = 1;
          else if (htrans == 2'd3) mcnt[m] = (mcnt[m] < 15) ? mcnt[m] + 1 : 15;
        end
      end
    end
    model_valid = 1'b1;
  end

  always @(negedge hclk) begin
    if (model_valid) begin
      check("m0_hgrant", int'(bus0.hgrant), 1 << mg[0]);
      check("m0_hmaster", int'(bus0.hmaster), mhm[0]);
      check("m0_hmaster_data", int'(bus0.hmaster_data), mhmd[0]);
      check("m0_hmastlock", int'(bus0.hmastlock), int'(mlk[0]));
      check("m1_hgrant", int'(bus1.hgrant), 1 << mg[1]);
      check("m1_hmaster", int'(bus1.hmaster), mhm[1]);
      check("m1_hmaster_data", int'(bus1.hmaster_data), mhmd[1]);
      check("m1_hmastlock", int'(bus1.hmastlock), int'(mlk[1]));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge hclk);
    #2;
  endtask

  int rr_seq[5] = '{2, 4, 8, 1, 2};

  initial begin
    // reset with no requests
    step(2);
    check("rst_hgrant", int'(bus0.hgrant), 1);
    check("rst_hmaster", int'(bus0.hmaster), 0);
    check("rst_hmaster_data", int'(bus0.hmaster_data), 0);
    check("rst_hmastlock", int'(bus0.hmastlock), 0);
    check("rst_rr_hgrant", int'(bus1.hgrant), 1);

    // fixed priority pipeline
    hreset = 1'b0; busreq = 4'b0110;
    step(1);
    check("prio_hgrant", int'(bus0.hgrant), 2);
    check("prio_hmaster_e1", int'(bus0.hmaster), 0);
    step(1);
    check("prio_hmaster_e2", int'(bus0.hmaster), 1);
    check("prio_hmaster_data_e2", int'(bus0.hmaster_data), 0);
    step(1);
    check("prio_hmaster_data_e3", int'(bus0.hmaster_data), 1);

    // round-robin rotation
    hreset = 1'b1; busreq = 4'b1111;
    step(1);
    hreset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("rr_rotate", int'(bus1.hgrant), rr_seq[i]);
    end

    // INCR4 burst holds grant until the last beat
    hreset = 1'b1; busreq = 4'b0100;
    step(1);
    hreset = 1'b0;
    step(1);
    check("burst_start_hgrant", int'(bus0.hgrant), 4);
    hburst = 3'd3; htrans = 2'd2;
    step(1);
    busreq = 4'b0101; htrans = 2'd3;
    step(1);
    check("burst_beat2", int'(bus0.hgrant), 4);
    step(1);
    check("burst_beat3", int'(bus0.hgrant), 4);
    step(1);
    check("burst_end_hgrant", int'(bus0.hgrant), 1);
    check("burst_end_rr_hgrant", int'(bus1.hgrant), 1);
    htrans = 2'd0; hburst = 3'd0;

    // locked master keeps the bus
    hreset = 1'b1;
    step(1);
    hreset = 1'b0; busreq = 4'b1000; hlock = 4'b1000;
    step(1);
    check("lock_grant", int'(bus0.hgrant), 8);
    step(1);
    check("lock_hmastlock", int'(bus0.hmastlock), 1);
    busreq = 4'b1001;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("lock_hold_hgrant", int'(bus0.hgrant), 8);
      check("lock_hold_hmastlock", int'(bus0.hmastlock), 1);
    end
    hlock = 4'b0000;
    step(1);
    check("unlock_hgrant", int'(bus0.hgrant), 1);
    check("unlock_hmastlock", int'(bus0.hmastlock), 0);

    // wait states mid-INCR8, then reset mid-burst
    hreset = 1'b1;
    step(1);
    hreset = 1'b0; busreq = 4'b0010; hburst = 3'd5;
    step(2);
    htrans = 2'd2; busreq = 4'b0011;
    step(1);
    htrans = 2'd3;
    step(2);
    check("incr8_hgrant", int'(bus0.hgrant), 2);
    check("incr8_hmaster_data", int'(bus0.hmaster_data), 1);
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("wait_hgrant", int'(bus0.hgrant), 2);
      check("wait_hmaster", int'(bus0.hmaster), 1);
      check("wait_hmaster_data", int'(bus0.hmaster_data), 1);
    end
    hreset = 1'b1;
    step(1);
    check("midrst_hgrant", int'(bus0.hgrant), 1);
    check("midrst_hmaster", int'(bus0.hmaster), 0);
    check("midrst_hmaster_data", int'(bus0.hmaster_data), 0);
    // a stale count of 3 would end this INCR4 immediately
    hreset = 1'b0; hready = 1'b1; hburst = 3'd3; htrans = 2'd3; busreq = 4'b0100;
    step(1);
    check("midrst_count_cleared", int'(bus0.hgrant), 1);
    htrans = 2'd0; hburst = 3'd0; busreq = 4'd0;

    for (int c = 0; c < 4000; c++) begin
      busreq = 4'($urandom);
      if ($urandom_range(0, 15) == 0) hlock = 4'($urandom);
      hready = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 7) == 0) hburst = 3'($urandom);
      case ($urandom_range(0, 7))
        0, 1:    htrans = 2'd0;
        2:       htrans = 2'd1;
        3:       htrans = 2'd2;
        default: htrans = 2'd3;
      endcase
      hreset = ($urandom_range(0, 199) == 0);
      step(1);
    end
    hreset = 1'b0;
    step(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
